ex_mem_stage: RTL
=================

# ex_mem_stage

EX/MEM boundary stage of the 5-stage pipelined ARM core, directly downstream of the 64-bit ALU. It captures the ALU result, store data and destination/control bits into the EX/MEM pipeline register, and maintains the architectural NZCV flag register updated by flag-setting instructions (ADDS/SUBS). It also resolves CBZ/B.cond branch decisions in EX, combinationally, for the fetch stage.

## Interface
Parameters:
- DATA_W, 64, datapath width
- REG_W, 5, register-index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  instruction in EX is real (not a bubble)
- alu_result  in  DATA_W  ALU result
- alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1 each  ALU flags
- ex_store_data  in  DATA_W  forwarded Rt value for STUR
- ex_rd  in  REG_W  destination register
- ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits
- ex_set_flags  in  1  instruction writes NZCV (ADDS/SUBS only)
- ex_is_cbz, ex_is_bcond  in  1 each  branch type
- ex_cond  in  4  B.cond condition code
- stall  in  1  hold stage
- flush  in  1  squash instruction in EX
- mem_valid, mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered
- mem_result, mem_store_data  out  DATA_W  registered
- mem_rd  out  REG_W  registered
- flags_q  out  4  NZCV register, bit order {N,Z,C,V}
- branch_taken  out  1  combinational branch decision

## Operation
- Register update each edge, priority: flush > stall > load.
- flush=1: mem_valid, mem_reg_write, mem_mem_read, mem_mem_write <= 0; data fields don't-care (hold); flags unchanged.
- stall=1, flush=0: every register (including flags_q) holds.
- Otherwise: all mem_* <= ex_* / alu_result; mem_valid <= ex_valid; control bits ANDed with ex_valid.
- Flag write enable = ex_valid & ex_set_flags & !stall & !flush; flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}.
- branch_taken = ex_valid & !flush & ((ex_is_cbz & alu_zero) | (ex_is_bcond & cond_true)). CBZ relies on ALU in PASS_B mode so alu_zero reflects Rt==0.
- cond_true evaluated on flags_q only (setter finishes EX one cycle before a dependent B.cond; no bypass):
  - 0000 EQ Z; 0001 NE !Z; 0010 HS C; 0011 LO !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110/1111 always.
- ALU carry/overflow are meaningless for non-add/sub ops; decode guarantees ex_set_flags only with ADD/SUB control.

## Timing
- Reset (async, immediate on rst_n low): all mem_* outputs 0, flags_q 4'b0000; branch_taken follows inputs (0 while ex_valid=0).
- Latency: EX inputs appear on mem_* and flags_q one cycle after the capturing edge.
- branch_taken: zero latency, same cycle as inputs.
- Reset released mid-stream: first edge after rst_n high loads normally.
- stall and flush together: flush wins (bubble inserted, flags held).

## Structure
- Shared package cpu_pkg: cond_e enum (EQ..NV, 4 bits), flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0, ALU control constants (PASS_B=000, ADD=010, SUB=011, AND=100, OR=101, XOR=110).
- One sub-module cond_check: inputs flags[3:0], cond[3:0]; output cond_true. Purely combinational, instantiated once.

## Test plan
- Reset: drive inputs nonzero, pulse rst_n low between edges -> all mem_* and flags_q read 0 before next edge.
- Flag set: ex_valid=1, ex_set_flags=1, alu_result=0, Z=1, C=1, N=0, V=0 -> next cycle flags_q=4'b0110, mem_result=0; following ADD with ex_set_flags=0 and N=1 -> flags_q stays 0110.
- B.cond: flags_q=4'b1001 (N=1,V=1), ex_is_bcond=1: ex_cond=1010 GE -> branch_taken=1; 1011 LT -> 0; 1100 GT -> 1; with ex_valid=0 -> 0.
- CBZ: ex_is_cbz=1, alu_zero=1 -> branch_taken=1; alu_zero=0 -> 0; flush=1 -> 0.
- Stall: load mem_result=64'h1234, then stall=1 for 3 cycles with changing inputs and ex_set_flags=1 -> mem_result=64'h1234 and flags_q unchanged throughout; release -> new values load next edge.
- Flush: ex_valid=1, ex_reg_write=1, ex_set_flags=1, flush=1 (and again with stall=1) -> mem_valid=0, mem_reg_write=0, flags_q unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared condition codes, NZCV flag indices and ALU control encodings.
package cpu_pkg;
   typedef enum logic [3:0] {
      EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
   } cond_e;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;
   localparam logic [2:0] ALU_PASS_B = 3'b000;
   localparam logic [2:0] ALU_ADD    = 3'b010;
   localparam logic [2:0] ALU_SUB    = 3'b011;
   localparam logic [2:0] ALU_AND    = 3'b100;
   localparam logic [2:0] ALU_OR     = 3'b101;
   localparam logic [2:0] ALU_XOR    = 3'b110;
endpackage

// File: rtl/cond_check.sv
// cond_check: evaluates an ARM B.cond condition code against the NZCV flags.
module cond_check
   import cpu_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [3:0] cond,
   output logic       cond_true
);
   logic n, z, c, v;
   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];
   always_comb begin
      cond_true = 1'b1;
      case (cond_e'(cond))
         EQ: cond_true = z;
         NE: cond_true = !z;
         HS: cond_true = c;
         LO: cond_true = !c;
         MI: cond_true = n;
         PL: cond_true = !n;
         VS: cond_true = v;
         VC: cond_true = !v;
         HI: cond_true = c & !z;
         LS: cond_true = !c | z;
         GE: cond_true = n == v;
         LT: cond_true = n != v;
         GT: cond_true = !z & (n == v);
         LE: cond_true = z | (n != v);
         default: cond_true = 1'b1;
      endcase
   end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register, NZCV flag register and EX-stage
// branch resolution for CBZ / B.cond.
module ex_mem_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_negative,
   input  logic              alu_zero,
   input  logic              alu_overflow,
   input  logic              alu_carry_out,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_set_flags,
   input  logic              ex_is_cbz,
   input  logic              ex_is_bcond,
   input  logic [3:0]        ex_cond,
   input  logic              stall,
   input  logic              flush,
   output logic              mem_valid,
   output logic              mem_reg_write,
   output logic              mem_mem_read,
   output logic              mem_mem_write,
   output logic [DATA_W-1:0] mem_result,
   output logic [DATA_W-1:0] mem_store_data,
   output logic [REG_W-1:0]  mem_rd,
   output logic [3:0]        flags_q,
   output logic              branch_taken
);
   logic       flag_we;
   logic [3:0] flags_d;
   logic       cond_true;
   cond_check u_cond (
      .flags    (flags_q),
      .cond     (ex_cond),
      .cond_true(cond_true)
   );
   assign flag_we = ex_valid & ex_set_flags & !stall & !flush;
   always_comb begin
      flags_d = flags_q;
      if (flag_we) begin
         flags_d[FLAG_N] = alu_negative;
         flags_d[FLAG_Z] = alu_zero;
         flags_d[FLAG_C] = alu_carry_out;
         flags_d[FLAG_V] = alu_overflow;
      end
   end
   // Branches read only the architectural flags; a setter always leaves EX first.
   assign branch_taken = ex_valid & !flush &
                         ((ex_is_cbz & alu_zero) | (ex_is_bcond & cond_true));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_valid      <= 1'b0;
         mem_reg_write  <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
         mem_result     <= '0;
         mem_store_data <= '0;
         mem_rd         <= '0;
         flags_q        <= 4'b0000;
      end else begin
         flags_q <= flags_d;
         if (flush) begin
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
         end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_reg_write  <= ex_valid & ex_reg_write;
            mem_mem_read   <= ex_valid & ex_mem_read;
            mem_mem_write  <= ex_valid & ex_mem_write;
            mem_result     <= alu_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
         end
      end
   end
endmodule
